// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the 9-bit datapath.
// No handshake: opcode/fcode/prog_done are sampled levels, the CTRL_* strobes are per-cycle levels.
interface multicycle_ctrl_if;
  logic [3:0] opcode;
  logic       fcode;
  logic       prog_done;
  logic       init;
  logic       pc_step;
  logic       CTRL_branch_rel_nz;
  logic       CTRL_branch_rel_z;
  logic       CTRL_branch_abs;
  logic       CTRL_reg_write_en;
  logic       CTRL_mem_to_reg;
  logic       CTRL_alu_src;
  logic       CTRL_alu_sc_in;
  logic       CTRL_read_mem;
  logic       CTRL_write_mem;
  logic [2:0] CTRL_alu_op;

  modport master (
    input  opcode, fcode, prog_done,
    output init, pc_step, CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
           CTRL_reg_write_en, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
           CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
  );

  modport slave (
    output opcode, fcode, prog_done,
    input  init, pc_step, CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
           CTRL_reg_write_en, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
           CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/EXEC/MEM/HALT timing, strobe decode and retired-instruction count.
// Outputs are registered from the next state and next ir, so they never follow opcode/fcode directly.
module multicycle_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             START,
  multicycle_ctrl_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FETCH = 3'd2,
    EXEC  = 3'd3,
    MEM   = 3'd4,
    HALT  = 3'd5
  } state_t;

  typedef struct packed {
    logic       init;
    logic       pc_step;
    logic       br_nz;
    logic       br_z;
    logic       br_abs;
    logic       reg_we;
    logic       mem_to_reg;
    logic       alu_src;
    logic       sc_in;
    logic       read_mem;
    logic       write_mem;
    logic [2:0] alu_op;
    logic       busy;
    logic       done;
  } out_t;

  state_t     state, nxt_state;
  logic [4:0] ir, nxt_ir;
  logic [3:0] cnt, nxt_cnt;
  logic       retire;
  out_t       outs;

  always_comb begin
    nxt_state = state;
    nxt_ir    = ir;
    nxt_cnt   = cnt;
    retire    = 1'b0;
    if (START) begin
      nxt_state = INIT;
    end else begin
      case (state)
        IDLE:  nxt_state = IDLE;
        INIT:  nxt_state = FETCH;
        FETCH: begin
          if (bus.prog_done) begin
            nxt_state = HALT;
          end else begin
            nxt_ir    = {bus.opcode, bus.fcode};
            nxt_state = EXEC;
          end
        end
        EXEC: begin
          retire = 1'b1;
          case (ir[4:1])
            4'b0110: begin
              retire    = 1'b0;
              nxt_state = MEM;
              nxt_cnt   = 4'(MEM_LATENCY - 1);
            end
            4'b1111: nxt_state = HALT;
            default: nxt_state = FETCH;
          endcase
        end
        MEM: begin
          if (cnt == 4'd0) begin
            retire    = 1'b1;
            nxt_state = FETCH;
          end else begin
            nxt_cnt = cnt - 4'd1;
          end
        end
        HALT:    nxt_state = HALT;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Decode for the cycle spent in state s with instruction i and memory counter c.
  function automatic out_t decode(input state_t s, input logic [4:0] i, input logic [3:0] c);
    out_t o;
    o      = '0;
    o.busy = (s != IDLE) && (s != HALT);
    o.done = (s == HALT);
    case (s)
      INIT: o.init = 1'b1;
      EXEC: begin
        case (i[4:1])
          4'b0000: begin o.alu_op = 3'b000; o.sc_in = i[0]; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0001: begin o.alu_op = 3'b001; o.sc_in = i[0]; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0010: begin o.alu_op = 3'b010; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0011: begin o.alu_op = i[0] ? 3'b100 : 3'b011; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0100: begin o.alu_op = i[0] ? 3'b110 : 3'b101; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0101: begin o.alu_op = 3'b000; o.alu_src = 1'b1; o.reg_we = 1'b1; o.pc_step = 1'b1; end
          4'b0110: o.read_mem = 1'b1;
          4'b0111: begin o.write_mem = 1'b1; o.pc_step = 1'b1; end
          4'b1000: o.br_z   = 1'b1;
          4'b1001: o.br_nz  = 1'b1;
          4'b1010: o.br_abs = 1'b1;
          4'b1111: o.pc_step = 1'b0;
          default: o.pc_step = 1'b1;
        endcase
      end
      MEM: begin
        o.read_mem = 1'b1;
        if (c == 4'd0) begin
          o.mem_to_reg = 1'b1;
          o.reg_we     = 1'b1;
          o.pc_step    = 1'b1;
        end
      end
      default: o.busy = o.busy;
    endcase
    return o;
  endfunction

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= '0;
      cnt     <= '0;
      retired <= '0;
      outs    <= '0;
    end else begin
      state <= nxt_state;
      ir    <= nxt_ir;
      cnt   <= nxt_cnt;
      outs  <= decode(nxt_state, nxt_ir, nxt_cnt);
      if (nxt_state == INIT)
        retired <= '0;
      else if (retire && (retired != {CNT_W{1'b1}}))
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign state_dbg              = state;
  assign busy                   = outs.busy;
  assign done                   = outs.done;
  assign bus.init               = outs.init;
  assign bus.pc_step            = outs.pc_step;
  assign bus.CTRL_branch_rel_nz = outs.br_nz;
  assign bus.CTRL_branch_rel_z  = outs.br_z;
  assign bus.CTRL_branch_abs    = outs.br_abs;
  assign bus.CTRL_reg_write_en  = outs.reg_we;
  assign bus.CTRL_mem_to_reg    = outs.mem_to_reg;
  assign bus.CTRL_alu_src       = outs.alu_src;
  assign bus.CTRL_alu_sc_in     = outs.sc_in;
  assign bus.CTRL_read_mem      = outs.read_mem;
  assign bus.CTRL_write_mem     = outs.write_mem;
  assign bus.CTRL_alu_op        = outs.alu_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: dut1 (MEM_LATENCY=3, CNT_W=16) and dut2 (MEM_LATENCY=1, CNT_W=2).
module tb_multicycle_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic        CLK = 1'b0;
  logic        reset, start1, start2;
  logic [3:0]  opcode;
  logic        fcode, prog_done;
  logic        busy1, done1, busy2, done2;
  logic [15:0] retired1;
  logic [1:0]  retired2;
  logic [2:0]  state_dbg1, state_dbg2;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;
  logic [15:0] exp_q[$];

  multicycle_ctrl_if bus1();
  multicycle_ctrl_if bus2();

  assign bus1.opcode = opcode;
  assign bus1.fcode = fcode;
  assign bus1.prog_done = prog_done;
  assign bus2.opcode = opcode;
  assign bus2.fcode = fcode;
  assign bus2.prog_done = prog_done;

  multicycle_ctrl #(.MEM_LATENCY(3), .CNT_W(16)) dut1 (
    .CLK(CLK), .reset(reset), .START(start1), .bus(bus1),
    .busy(busy1), .done(done1), .retired(retired1), .state_dbg(state_dbg1)
  );

  multicycle_ctrl #(.MEM_LATENCY(1), .CNT_W(2)) dut2 (
    .CLK(CLK), .reset(reset), .START(start2), .bus(bus2),
    .busy(busy2), .done(done2), .retired(retired2), .state_dbg(state_dbg2)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {init, pc_step, br_nz, br_z, br_abs, we, m2r, alu_src, sc_in, rd, wr, alu_op, busy, done}
  function automatic logic [15:0] obs1();
    return {bus1.init, bus1.pc_step, bus1.CTRL_branch_rel_nz, bus1.CTRL_branch_rel_z,
            bus1.CTRL_branch_abs, bus1.CTRL_reg_write_en, bus1.CTRL_mem_to_reg,
            bus1.CTRL_alu_src, bus1.CTRL_alu_sc_in, bus1.CTRL_read_mem,
            bus1.CTRL_write_mem, bus1.CTRL_alu_op, busy1, done1};
  endfunction

  function automatic logic [15:0] mk(input logic pc, nz, z, ab, we, m2r, src, sc, rd, wr,
                                     input logic [2:0] op);
    return {1'b0, pc, nz, z, ab, we, m2r, src, sc, rd, wr, op, 1'b1, 1'b0};
  endfunction

  // driver tasks
  task automatic start_dut1();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (obs1() !== 16'h8002 || state_dbg1 !== S_INIT) begin
      failures++;
      $display("FAIL init_cycle got=%h/%0d exp=8002/%0d", obs1(), state_dbg1, S_INIT);
    end
    tick();
    exp_ret = 0;
    checks++;
    if (obs1() !== 16'h0002 || retired1 !== 16'd0) begin
      failures++;
      $display("FAIL fetch_after_init got=%h ret=%0d exp=0002 ret=0", obs1(), retired1);
    end
  endtask

  // Issues one single-EXEC instruction from FETCH and returns in FETCH.
  task automatic run_instr(input logic [3:0] op, input logic f, input logic [15:0] e);
    logic [15:0] exp_v;
    exp_q.push_back(e);
    opcode = op;
    fcode = f;
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs1() !== exp_v) begin
      failures++;
      $display("FAIL exec_vec op=%b f=%b got=%h exp=%h", op, f, obs1(), exp_v);
    end
    opcode = 4'($urandom_range(0, 15));
    fcode = 1'($urandom_range(0, 1));
    tick();
    exp_ret++;
    checks++;
    if (retired1 !== 16'(exp_ret) || state_dbg1 !== S_FETCH) begin
      failures++;
      $display("FAIL retired op=%b got=%0d st=%0d exp=%0d st=%0d", op, retired1, state_dbg1, exp_ret, S_FETCH);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    opcode = 4'd0; fcode = 1'b0; prog_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs1() !== 16'h0000 || state_dbg1 !== S_IDLE || retired1 !== 16'd0 || retired2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%h st=%0d ret=%0d exp=0000 st=0 ret=0", obs1(), state_dbg1, retired1);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops[11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b0100,
                             4'b0100, 4'b0101, 4'b0001, 4'b1011, 4'b1100};
    logic        fs[11]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] es[11];
    es[0]  = mk(1,0,0,0,1,0,0,1,0,0,3'b000);
    es[1]  = mk(1,0,0,0,1,0,0,0,0,0,3'b001);
    es[2]  = mk(1,0,0,0,1,0,0,0,0,0,3'b010);
    es[3]  = mk(1,0,0,0,1,0,0,0,0,0,3'b011);
    es[4]  = mk(1,0,0,0,1,0,0,0,0,0,3'b100);
    es[5]  = mk(1,0,0,0,1,0,0,0,0,0,3'b101);
    es[6]  = mk(1,0,0,0,1,0,0,0,0,0,3'b110);
    es[7]  = mk(1,0,0,0,1,0,1,0,0,0,3'b000);
    es[8]  = mk(1,0,0,0,1,0,0,1,0,0,3'b001);
    es[9]  = mk(1,0,0,0,0,0,0,0,0,0,3'b000);
    es[10] = mk(1,0,0,0,0,0,0,0,0,0,3'b000);
    start_dut1();
    for (int i = 0; i < 11; i++) run_instr(ops[i], fs[i], es[i]);
  endtask

  task automatic test_load();
    logic [15:0] e;
    opcode = 4'b0110; fcode = 1'b0;
    tick();
    checks++;
    if (obs1() !== mk(0,0,0,0,0,0,0,0,1,0,3'b000)) begin
      failures++;
      $display("FAIL load_exec got=%h exp=%h", obs1(), mk(0,0,0,0,0,0,0,0,1,0,3'b000));
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = (k < 3) ? mk(0,0,0,0,0,0,0,0,1,0,3'b000) : mk(1,0,0,0,1,1,0,0,1,0,3'b000);
      checks++;
      if (obs1() !== e || state_dbg1 !== S_MEM || retired1 !== 16'(exp_ret)) begin
        failures++;
        $display("FAIL load_mem%0d got=%h st=%0d ret=%0d exp=%h st=%0d ret=%0d", k, obs1(), state_dbg1, retired1, e, S_MEM, exp_ret);
      end
    end
    tick();
    exp_ret++;
    checks++;
    if (state_dbg1 !== S_FETCH || retired1 !== 16'(exp_ret) || bus1.CTRL_read_mem !== 1'b0) begin
      failures++;
      $display("FAIL load_done st=%0d ret=%0d rd=%b exp st=%0d ret=%0d rd=0", state_dbg1, retired1, bus1.CTRL_read_mem, S_FETCH, exp_ret);
    end
  endtask

  task automatic test_load_abort();
    opcode = 4'b0110; fcode = 1'b1;
    repeat (3) tick();
    start1 = 1'b1;
    checks++;
    if (obs1() !== mk(0,0,0,0,0,0,0,0,1,0,3'b000) || state_dbg1 !== S_MEM) begin
      failures++;
      $display("FAIL abort_mem2 got=%h st=%0d exp=%h st=%0d", obs1(), state_dbg1, mk(0,0,0,0,0,0,0,0,1,0,3'b000), S_MEM);
    end
    tick();
    start1 = 1'b0;
    checks++;
    if (obs1() !== 16'h8002 || state_dbg1 !== S_INIT) begin
      failures++;
      $display("FAIL abort_init got=%h st=%0d exp=8002 st=%0d", obs1(), state_dbg1, S_INIT);
    end
    tick();
    exp_ret = 0;
    checks++;
    if (retired1 !== 16'd0 || state_dbg1 !== S_FETCH) begin
      failures++;
      $display("FAIL abort_retired got=%0d st=%0d exp=0 st=%0d", retired1, state_dbg1, S_FETCH);
    end
  endtask

  task automatic test_branches();
    run_instr(4'b1000, 1'b0, mk(0,0,1,0,0,0,0,0,0,0,3'b000));
    run_instr(4'b1001, 1'b1, mk(0,1,0,0,0,0,0,0,0,0,3'b000));
    run_instr(4'b1010, 1'b0, mk(0,0,0,1,0,0,0,0,0,0,3'b000));
    run_instr(4'b0111, 1'b1, mk(1,0,0,0,0,0,0,0,0,1,3'b000));
    checks++;
    if (retired1 !== 16'd4) begin
      failures++;
      $display("FAIL branch_count got=%0d exp=4", retired1);
    end
  endtask

  task automatic hold_halt(input string tag);
    for (int k = 0; k < 10; k++) begin
      opcode = 4'($urandom_range(0, 15));
      fcode = 1'($urandom_range(0, 1));
      checks++;
      if (obs1() !== 16'h0001 || state_dbg1 !== S_HALT || retired1 !== 16'(exp_ret)) begin
        failures++;
        $display("FAIL %s cyc=%0d got=%h st=%0d ret=%0d exp=0001 st=%0d ret=%0d", tag, k, obs1(), state_dbg1, retired1, S_HALT, exp_ret);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp_v;
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0;
    hold_halt("halt_prog_done");
    start_dut1();
    exp_q.push_back(16'h0002);
    opcode = 4'b1111; fcode = 1'b0;
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs1() !== exp_v) begin
      failures++;
      $display("FAIL halt_exec got=%h exp=%h", obs1(), exp_v);
    end
    tick();
    exp_ret++;
    hold_halt("halt_opcode");
    start_dut1();
  endtask

  task automatic test_async_reset();
    run_instr(4'b0010, 1'b0, mk(1,0,0,0,1,0,0,0,0,0,3'b010));
    opcode = 4'b0000; fcode = 1'b0;
    tick();
    checks++;
    if (bus1.CTRL_reg_write_en !== 1'b1 || retired1 !== 16'(exp_ret)) begin
      failures++;
      $display("FAIL pre_reset_exec we=%b ret=%0d exp we=1 ret=%0d", bus1.CTRL_reg_write_en, retired1, exp_ret);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs1() !== 16'h0000 || state_dbg1 !== S_IDLE || retired1 !== 16'd0) begin
      failures++;
      $display("FAIL async_reset got=%h st=%0d ret=%0d exp=0000 st=0 ret=0", obs1(), state_dbg1, retired1);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if (bus2.init !== 1'b1 || busy2 !== 1'b1) begin
      failures++;
      $display("FAIL sat_init got init=%b busy=%b exp init=1 busy=1", bus2.init, busy2);
    end
    tick();
    for (int k = 1; k <= 5; k++) begin
      opcode = 4'b1101; fcode = 1'($urandom_range(0, 1));
      tick();
      tick();
      checks++;
      if (retired2 !== 2'((k > 3) ? 3 : k)) begin
        failures++;
        $display("FAIL sat_count n=%0d got=%0d exp=%0d", k, retired2, (k > 3) ? 3 : k);
      end
    end
    opcode = 4'b0110; fcode = 1'b0;
    tick();
    checks++;
    if (bus2.CTRL_read_mem !== 1'b1 || bus2.CTRL_reg_write_en !== 1'b0) begin
      failures++;
      $display("FAIL lat1_exec got rd=%b we=%b exp rd=1 we=0", bus2.CTRL_read_mem, bus2.CTRL_reg_write_en);
    end
    tick();
    checks++;
    if (state_dbg2 !== S_MEM || bus2.CTRL_read_mem !== 1'b1 || bus2.CTRL_reg_write_en !== 1'b1 || bus2.CTRL_mem_to_reg !== 1'b1) begin
      failures++;
      $display("FAIL lat1_mem st=%0d rd=%b we=%b m2r=%b exp st=%0d 1 1 1", state_dbg2, bus2.CTRL_read_mem, bus2.CTRL_reg_write_en, bus2.CTRL_mem_to_reg, S_MEM);
    end
    tick();
    checks++;
    if (state_dbg2 !== S_FETCH || retired2 !== 2'd3) begin
      failures++;
      $display("FAIL lat1_done st=%0d ret=%0d exp st=%0d ret=3", state_dbg2, retired2, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_load_abort();
    test_branches();
    test_halt();
    test_async_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
